// File: rtl/fifo_frame_tx.sv
// fifo_frame_tx: buffers up to 8 client bytes and sends them downstream as
// one frame, a header byte followed by the payload bytes.
//
// Ports:
//   CLK         clock, rising edge
//   RESET       asynchronous active-high reset
//   in_wren     client write strobe
//   in_wrfull   block cannot take a byte this cycle
//   in_wrdata   client write byte
//   flush       send buffered bytes now
//   out_wren    downstream write strobe
//   out_wrfull  downstream cannot take a byte
//   out_wrdata  header or payload byte
//   busy        a frame is being sent (HDR or PAY)
//
// Header layout: CLIENT_ID at bit SELBIT, (count-1) in bits
// CNTLSB+2:CNTLSB, all other bits zero.
module fifo_frame_tx #(
    parameter int SELBIT    = 7,
    parameter int CLIENT_ID = 0,
    parameter int CNTLSB    = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       in_wren,
    output logic       in_wrfull,
    input  logic [7:0] in_wrdata,
    input  logic       flush,
    output logic       out_wren,
    input  logic       out_wrfull,
    output logic [7:0] out_wrdata,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2
    } state_t;

    localparam logic [7:0] TMAX = 8'(TIMEOUT);

    state_t     state;
    logic [3:0] count;
    logic [2:0] rdidx;
    logic [7:0] timer;
    logic [7:0] mem [8];

    logic       accept;
    logic [3:0] count_nxt;
    logic       start;
    logic [2:0] cnt_m1;
    logic       last;
    logic [7:0] header;

    // Handshake and frame-start decode.
    always_comb begin
        in_wrfull = (state != IDLE) || (count == 4'd8);
        busy      = (state != IDLE);
        out_wren  = (state != IDLE) && !out_wrfull;

        accept    = in_wren && !in_wrfull;
        count_nxt = count + {3'b000, accept};

        // The decision uses the count after this cycle's write, so a byte
        // written together with flush still lands in the frame.
        start = (count_nxt == 4'd8) ||
                ((count_nxt != 4'd0) && (flush || (timer == TMAX)));

        cnt_m1 = 3'(count - 4'd1);
        last   = (rdidx == cnt_m1);
    end

    // Header byte built from the parameters and the current fill level.
    always_comb begin
        header               = '0;
        header[SELBIT]       = 1'(CLIENT_ID);
        header[CNTLSB +: 3]  = cnt_m1;
    end

    // Output byte mux; zero while idle so the port is quiet between frames.
    always_comb begin
        out_wrdata = 8'h00;
        unique case (state)
            IDLE:    out_wrdata = 8'h00;
            HDR:     out_wrdata = header;
            PAY:     out_wrdata = mem[rdidx];
            default: out_wrdata = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            count <= 4'd0;
            rdidx <= 3'd0;
            timer <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mem[count[2:0]] <= in_wrdata;
                    end
                    count <= count_nxt;
                    // Timer only runs while partial data waits.
                    if (accept || (count == 4'd0)) begin
                        timer <= 8'd0;
                    end else if (timer != TMAX) begin
                        timer <= timer + 8'd1;
                    end
                    if (start) begin
                        state <= HDR;
                    end
                end
                HDR: begin
                    if (out_wren) begin
                        state <= PAY;
                        rdidx <= 3'd0;
                    end
                end
                PAY: begin
                    if (out_wren) begin
                        if (last) begin
                            state <= IDLE;
                            count <= 4'd0;
                            timer <= 8'd0;
                            rdidx <= 3'd0;
                        end else begin
                            rdidx <= rdidx + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
